// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   owner_t     : which requester currently owns the memory port
//   MEM_LAT_MAX : largest memory latency the 4-bit latency counter can cover
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF)
// and data memory (DM) requesters. Requests are serialised, each access
// ends with a one-cycle done pulse, read data is held in registers, and a
// pipeline-wide stall is raised until every outstanding request of the
// current pipeline step has been served.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (level) and address
//   if_rdata/if_done              registered instruction, completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata load/store request (dm_we!=0 -> store)
//   dm_rdata/dm_done              registered load data, completion pulse
//   stall                         freeze pipeline registers
//   mem_cs/mem_we/mem_addr/mem_wdata  memory issue strobe and command
//   mem_rdata                     memory read data, valid MEM_LAT cycles after issue
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                stall,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  // Legal latencies are 1..MEM_LAT_MAX; clamp so the counter load always fits.
  localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                           ((MEM_LAT < 1) ? 1 : MEM_LAT);
  localparam logic [3:0] LAT_INIT = 4'(LAT_EFF - 1);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next;
  owner_t            last_grant_reg, last_grant_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              is_store_reg, is_store_next;
  logic              served_if_reg, served_if_next;
  logic              served_dm_reg, served_dm_next;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;

  logic              pend_if, pend_dm, grant_dm;
  logic              capture_if, capture_dm;
  logic              issue;
  logic [BE_W-1:0]   issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  assign pend_if  = if_req & ~served_if_reg;
  assign pend_dm  = dm_req & ~served_dm_reg;
  // DM wins when it is the only one pending, or on a tie if IF was granted last.
  assign grant_dm = pend_dm & (~pend_if | (last_grant_reg == OWN_IF));

  assign if_done = (state_reg == RESP) && (owner_reg == OWN_IF);
  assign dm_done = (state_reg == RESP) && (owner_reg == OWN_DM);

  // A requester whose done is pulsing this cycle no longer holds the pipeline.
  assign stall = ((state_reg != IDLE) & ~(if_done | dm_done)) |
                 (pend_if & ~if_done) |
                 (pend_dm & ~dm_done);

  // FSM next-state and memory command
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    is_store_next   = is_store_reg;
    capture_if      = 1'b0;
    capture_dm      = 1'b0;
    issue           = 1'b0;
    issue_we        = '0;
    issue_addr      = '0;
    issue_wdata     = '0;

    unique case (state_reg)
      IDLE: begin
        if (pend_if | pend_dm) begin
          issue           = 1'b1;
          owner_next      = grant_dm ? OWN_DM : OWN_IF;
          last_grant_next = grant_dm ? OWN_DM : OWN_IF;
          cnt_next        = LAT_INIT;
          is_store_next   = grant_dm & (|dm_we);
          state_next      = WAIT;
          if (grant_dm) begin
            issue_we    = dm_we;
            issue_addr  = dm_addr;
            issue_wdata = dm_wdata;
          end else begin
            issue_addr  = if_addr;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture_if = (owner_reg == OWN_IF);
          capture_dm = (owner_reg == OWN_DM) & ~is_store_reg;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The grant is combinational from IDLE, so the strobe and write enables are
  // explicitly held low while reset is asserted.
  assign mem_cs    = issue & ~rst;
  assign mem_we    = issue_we & {BE_W{~rst}};
  assign mem_addr  = issue_addr;
  assign mem_wdata = issue_wdata;

  // A pipeline advance (stall low) clears both flags and overrides a set.
  assign served_if_next = stall & (served_if_reg | if_done);
  assign served_dm_next = stall & (served_dm_reg | dm_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      last_grant_reg <= OWN_IF;
      cnt_reg        <= 4'd0;
      is_store_reg   <= 1'b0;
      served_if_reg  <= 1'b0;
      served_dm_reg  <= 1'b0;
      if_rdata_reg   <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      is_store_reg   <= is_store_next;
      served_if_reg  <= served_if_next;
      served_dm_reg  <= served_dm_next;
      if (capture_if) if_rdata_reg <= mem_rdata;
      if (capture_dm) dm_rdata_reg <= mem_rdata;
    end
  end

  assign if_rdata = if_rdata_reg;
  assign dm_rdata = dm_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Instance 0 uses MEM_LAT=1,
// instance 1 uses MEM_LAT=3; each has its own behavioural memory whose
// read data appears exactly MEM_LAT cycles after the issue edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;

  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_done   [2];
  logic        dm_req    [2];
  logic [3:0]  dm_we     [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic [31:0] dm_rdata  [2];
  logic        dm_done   [2];
  logic        stall     [2];
  logic        mem_cs    [2];
  logic [3:0]  mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0000_0013;
      32'h20:  return 32'h0050_0093;
      32'h100: return 32'h1111_2222;
      32'h104: return 32'h1234_5678;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    bit   [31:0] mem [256];
    bit          touched [256];
    logic [31:0] dl [15];
    logic [31:0] rd_word, wr_word;
    logic [7:0]  idx;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[gi]), .if_addr(if_addr[gi]),
      .if_rdata(if_rdata[gi]), .if_done(if_done[gi]),
      .dm_req(dm_req[gi]), .dm_we(dm_we[gi]), .dm_addr(dm_addr[gi]),
      .dm_wdata(dm_wdata[gi]), .dm_rdata(dm_rdata[gi]), .dm_done(dm_done[gi]),
      .stall(stall[gi]),
      .mem_cs(mem_cs[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi])
    );

    always_comb begin
      idx     = mem_addr[gi][9:2];
      rd_word = touched[idx] ? mem[idx] : init_word(mem_addr[gi]);
      wr_word = rd_word;
      for (int b = 0; b < 4; b++)
        if (mem_we[gi][b]) wr_word[8*b +: 8] = mem_wdata[gi][8*b +: 8];
    end

    // Poison value marks cycles where no read data is valid.
    always @(posedge clk) begin
      if (mem_cs[gi] && mem_we[gi] != 4'd0) begin
        mem[idx]     <= wr_word;
        touched[idx] <= 1'b1;
      end
      dl[0] <= (mem_cs[gi] && mem_we[gi] == 4'd0) ? rd_word : 32'hA5A5_A5A5;
      for (int j = 1; j < 15; j++) dl[j] <= dl[j-1];
    end

    assign mem_rdata[gi] = dl[LAT-1];
  end

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
  endtask

  // Leaves the caller just after a rising edge with reset released: the
  // following negedge belongs to cycle 0.
  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    if_req[0] = 1'b1; dm_req[0] = 1'b1; dm_we[0] = 4'hF; dm_addr[0] = 32'h40;
    @(negedge clk);
    checks++; if (mem_cs[0] !== 1'b0) begin failures++; $display("FAIL reset_mem_cs got=%b exp=0", mem_cs[0]); end
    checks++; if (mem_we[0] !== 4'h0) begin failures++; $display("FAIL reset_mem_we got=%h exp=0", mem_we[0]); end
    checks++; if (if_done[0] !== 1'b0 || dm_done[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", if_done[0], dm_done[0]); end
    checks++; if (if_rdata[0] !== 32'h0) begin failures++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata[0]); end
    checks++; if (dm_rdata[0] !== 32'h0) begin failures++; $display("FAIL reset_dm_rdata got=%h exp=0", dm_rdata[0]); end
    $display("txn reset: outputs idle while rst high");
  endtask

  task automatic test_if_only();
    apply_reset();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (mem_cs[0] !== (c == 0)) begin failures++; $display("FAIL if_only_cs c%0d got=%b exp=%b", c, mem_cs[0], (c == 0)); end
      checks++; if (stall[0] !== (c < 2)) begin failures++; $display("FAIL if_only_stall c%0d got=%b exp=%b", c, stall[0], (c < 2)); end
      checks++; if (if_done[0] !== (c == 2)) begin failures++; $display("FAIL if_only_done c%0d got=%b exp=%b", c, if_done[0], (c == 2)); end
      if (c == 0) begin
        checks++; if (mem_addr[0] !== 32'h10 || mem_we[0] !== 4'h0) begin failures++; $display("FAIL if_only_issue got addr=%h we=%h exp addr=10 we=0", mem_addr[0], mem_we[0]); end
      end
      if (c == 2) begin
        checks++; if (if_rdata[0] !== 32'h13) begin failures++; $display("FAIL if_only_rdata got=%h exp=00000013", if_rdata[0]); end
        $display("txn if_only: addr=0x10 rdata=%h", if_rdata[0]);
      end
    end
    @(posedge clk); #1 if_req[0] = 1'b0;
    @(negedge clk);
    checks++; if (mem_cs[0] !== 1'b0) begin failures++; $display("FAIL if_only_idle_cs got=%b exp=0", mem_cs[0]); end
  endtask

  task automatic test_both();
    apply_reset();
    dm_req[0] = 1'b1; dm_addr[0] = 32'h100;
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (mem_cs[0] !== (c == 0 || c == 3)) begin failures++; $display("FAIL both_cs c%0d got=%b exp=%b", c, mem_cs[0], (c == 0 || c == 3)); end
      checks++; if (stall[0] !== (c < 5)) begin failures++; $display("FAIL both_stall c%0d got=%b exp=%b", c, stall[0], (c < 5)); end
      checks++; if (dm_done[0] !== (c == 2) || if_done[0] !== (c == 5)) begin failures++; $display("FAIL both_done c%0d got dm=%b if=%b", c, dm_done[0], if_done[0]); end
      if (c == 0) begin
        checks++; if (mem_addr[0] !== 32'h100) begin failures++; $display("FAIL both_addr_dm got=%h exp=00000100", mem_addr[0]); end
      end
      if (c == 3) begin
        checks++; if (mem_addr[0] !== 32'h20) begin failures++; $display("FAIL both_addr_if got=%h exp=00000020", mem_addr[0]); end
      end
      if (c == 2) begin
        checks++; if (dm_rdata[0] !== 32'h1111_2222) begin failures++; $display("FAIL both_dm_rdata got=%h exp=11112222", dm_rdata[0]); end
        $display("txn both: dm load 0x100 rdata=%h", dm_rdata[0]);
      end
      if (c == 5) begin
        checks++; if (if_rdata[0] !== 32'h0050_0093) begin failures++; $display("FAIL both_if_rdata got=%h exp=00500093", if_rdata[0]); end
        $display("txn both: if fetch 0x20 rdata=%h", if_rdata[0]);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  // Runs straight after test_both so dm_rdata still holds the earlier load.
  task automatic test_store();
    dm_req[0] = 1'b1; dm_we[0] = 4'b0011; dm_addr[0] = 32'h104; dm_wdata[0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (mem_cs[0] !== (c == 0)) begin failures++; $display("FAIL store_cs c%0d got=%b exp=%b", c, mem_cs[0], (c == 0)); end
      checks++; if (dm_done[0] !== (c == 2)) begin failures++; $display("FAIL store_done c%0d got=%b exp=%b", c, dm_done[0], (c == 2)); end
      if (c == 0) begin
        checks++; if (mem_we[0] !== 4'b0011 || mem_wdata[0] !== 32'hDEAD_BEEF || mem_addr[0] !== 32'h104) begin
          failures++; $display("FAIL store_issue got we=%b wdata=%h addr=%h exp we=0011 wdata=deadbeef addr=104", mem_we[0], mem_wdata[0], mem_addr[0]); end
      end
      if (c == 2) begin
        checks++; if (dm_rdata[0] !== 32'h1111_2222) begin failures++; $display("FAIL store_rdata_hold got=%h exp=11112222", dm_rdata[0]); end
        $display("txn store: addr=0x104 we=0011 wdata=deadbeef");
      end
    end
    @(posedge clk); #1 dm_we[0] = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (dm_done[0] !== (c == 2)) begin failures++; $display("FAIL readback_done c%0d got=%b exp=%b", c, dm_done[0], (c == 2)); end
      if (c == 2) begin
        checks++; if (dm_rdata[0] !== 32'h1234_BEEF) begin failures++; $display("FAIL readback_rdata got=%h exp=1234beef", dm_rdata[0]); end
        $display("txn readback: addr=0x104 rdata=%h", dm_rdata[0]);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_latency();
    apply_reset();
    dm_req[1] = 1'b1; dm_addr[1] = 32'h100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (mem_cs[1] !== (c == 0)) begin failures++; $display("FAIL lat_cs c%0d got=%b exp=%b", c, mem_cs[1], (c == 0)); end
      checks++; if (dm_done[1] !== (c == 4)) begin failures++; $display("FAIL lat_done c%0d got=%b exp=%b", c, dm_done[1], (c == 4)); end
      checks++; if (stall[1] !== (c < 4)) begin failures++; $display("FAIL lat_stall c%0d got=%b exp=%b", c, stall[1], (c < 4)); end
      if (c == 4) begin
        checks++; if (dm_rdata[1] !== 32'h1111_2222) begin failures++; $display("FAIL lat_rdata got=%h exp=11112222", dm_rdata[1]); end
        $display("txn latency3: dm load 0x100 rdata=%h", dm_rdata[1]);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    dm_req[1] = 1'b1; dm_addr[1] = 32'h100;
    @(negedge clk);
    checks++; if (mem_cs[1] !== 1'b1) begin failures++; $display("FAIL midwait_cs0 got=%b exp=1", mem_cs[1]); end
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (dm_done[1] !== 1'b0 || mem_cs[1] !== 1'b0) begin failures++; $display("FAIL midwait_rst c%0d got done=%b cs=%b exp 0 0", c, dm_done[1], mem_cs[1]); end
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (mem_cs[1] !== (c == 0)) begin failures++; $display("FAIL midwait_recs c%0d got=%b exp=%b", c, mem_cs[1], (c == 0)); end
      checks++; if (dm_done[1] !== (c == 4)) begin failures++; $display("FAIL midwait_done c%0d got=%b exp=%b", c, dm_done[1], (c == 4)); end
      if (c == 4) begin
        checks++; if (dm_rdata[1] !== 32'h1111_2222) begin failures++; $display("FAIL midwait_rdata got=%h exp=11112222", dm_rdata[1]); end
        $display("txn reset_mid_wait: reissued load rdata=%h", dm_rdata[1]);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_fairness();
    logic [31:0] exp_addr;
    apply_reset();
    dm_req[0] = 1'b1; dm_addr[0] = 32'h100;
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_addr = (((c / 3) % 2) == 0) ? 32'h100 : 32'h20;
      checks++; if (mem_cs[0] !== ((c % 3) == 0)) begin failures++; $display("FAIL fair_cs c%0d got=%b exp=%b", c, mem_cs[0], ((c % 3) == 0)); end
      checks++; if (stall[0] !== ((c % 6) != 5)) begin failures++; $display("FAIL fair_stall c%0d got=%b exp=%b", c, stall[0], ((c % 6) != 5)); end
      if ((c % 3) == 0) begin
        checks++; if (mem_addr[0] !== exp_addr) begin failures++; $display("FAIL fair_grant c%0d got=%h exp=%h", c, mem_addr[0], exp_addr); end
        $display("txn fairness: grant c%0d addr=%h", c, mem_addr[0]);
      end
    end
    @(posedge clk); #1 clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_if_only();
    test_both();
    test_store();
    test_latency();
    test_reset_mid_wait();
    test_fairness();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the pipeline's instruction fetch (IF) and data-memory (MEM-stage load/store) requesters. It serialises the two requests and pulses a per-requester done. It holds returned read data in registers and drives a pipeline-wide `stall` until every outstanding request of the current pipeline step is served. It sits between the core pipeline, whose DM request is `mem_r | mem_w` from the control decoder, and the shared memory macro.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, data width (byte enables = `DATA_W/8`)
- `MEM_LAT`, 1, cycles from issue edge to valid `mem_rdata`; legal range 1..15

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request, level, held until served
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  registered fetched instruction
- `if_done`  out  1  one-cycle pulse, fetch complete
- `dm_req`  in  1  load/store request, level
- `dm_we`  in  DATA_W/8  byte write enables; nonzero = store
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  registered load data
- `dm_done`  out  1  one-cycle pulse, load/store complete
- `stall`  out  1  freeze pipeline registers
- `mem_cs`  out  1  memory chip select, one-cycle issue strobe
- `mem_we`  out  DATA_W/8  memory byte write enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WAIT, RESP. A 4-bit latency counter is included.
- `served_if` and `served_dm` are flags. `last_grant` is either IF or DM.
- Pending for requester x: `pending_x = x_req & ~served_x`.
- IDLE, with no pending request: all memory outputs are 0 and the FSM stays in IDLE.
- IDLE, with one pending request: grant it.
- IDLE, with both pending: grant the one that is not `last_grant`.
- Grant cycle:
  - `mem_cs=1`.
  - `mem_addr`, `mem_we` and `mem_wdata` pass through combinationally from the owner.
  - IF always issues `mem_we=0`, `mem_wdata=0`.
  - Latch the owner, set `last_grant`, load counter with `MEM_LAT-1`, go to WAIT.
- WAIT:
  - `mem_cs=0`.
  - If the counter is 0, capture `mem_rdata` into the owner's rdata register (reads only; stores leave `dm_rdata` unchanged), then go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - Owner's done = 1.
  - Set `served_owner` at the end of the cycle.
  - Go to IDLE. No grant is issued in RESP.
- Stall equation: `stall = (state!=IDLE & ~owner_done) | pending_if_excl | pending_dm_excl`.
  - `pending_x_excl` is `pending_x`, excluding x while x_done is high.
  - Equivalently, stall is low only in a cycle where nothing is in flight and every asserted request is served or done this cycle.
- Flag clearing: any cycle with `stall=0` clears both served flags at its end, because the pipeline advances. This wins over a set in the same cycle.
- A requester that drops req mid-transaction is a protocol violation. The transaction still completes and the done still pulses.
- rdata registers hold their value until the next capture for the same requester.

## Timing
- Per-transaction occupancy is `MEM_LAT+2` cycles: grant at cycle 0, capture at the end of cycle `MEM_LAT`, done in cycle `MEM_LAT+1`.
- Back-to-back: the next grant comes no earlier than the cycle after RESP.
- Reset (async, any state, including mid-WAIT):
  - State = IDLE, counter = 0, served flags = 0, `last_grant` = IF (so DM wins the first tie).
  - `if_rdata` = `dm_rdata` = 0, both done = 0.
  - `mem_cs`/`mem_we` = 0 while `rst` is high.
  - The in-flight access is abandoned with no done.
  - After release, requests still held are re-issued.
- `stall` is combinational from state and requests. With reset released and a request high, it is 1 in the same cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP}` state.
  - `typedef enum logic {OWN_IF, OWN_DM}` owner.
  - Constant `MEM_LAT_MAX = 15`.
- No sub-module. Counter, FSM and flags are implemented inline.

## Test plan
- **IF only** (`MEM_LAT=1`): `if_req=1`, `if_addr=0x10`, `mem_rdata=0x00000013` in cycle 1 -> cycle 0 `mem_cs=1 mem_addr=0x10 mem_we=0`; cycle 2 `if_done=1 if_rdata=0x13`; `stall` is 1 in cycles 0–1 and 0 in cycle 2.
- **Both requests at once after reset**: DM load at 0x100 and IF at 0x20 -> DM issued cycle 0, `dm_done` cycle 2; IF issued cycle 3, `if_done` cycle 5; `stall` is 1 in cycles 0–4 and 0 in cycle 5; DM is not re-issued.
- **Store**: `dm_we=4'b0011`, `dm_wdata=0xDEADBEEF`, `dm_addr=0x104` -> issue cycle shows `mem_we=0011` and wdata 0xDEADBEEF; `dm_done` at cycle 2; `dm_rdata` keeps its prior value.
- **Latency** (`MEM_LAT=3`): single DM load -> `dm_done` in cycle 4; `mem_cs` is high only in cycle 0.
- **Reset mid-WAIT** (`MEM_LAT=3`): `rst` pulsed in cycle 2 -> no done, served flags cleared; after release the held request is re-granted and completes normally.
- **Fairness**: both requests held across two pipeline advances -> grant order DM, IF, DM, IF.
